// File: rtl/hdr_in_fifo_pkg.sv
// Shared byte-bus width and maximum header length for the ingress header path.
package hdr_in_fifo_pkg;
   localparam int unsigned ByteW     = 8;
   localparam int unsigned HdrMaxLen = 64;

   typedef logic [ByteW-1:0] byte_t;
endpackage

// File: rtl/hdr_in_fifo.sv
// Ingress header buffer: captures the first HDR_LEN bytes of each packet into DEPTH slots
// and presents the oldest header to the packet processor; packets arriving while full are dropped.
module hdr_in_fifo
   import hdr_in_fifo_pkg::*;
#(
   parameter int unsigned HDR_LEN = HdrMaxLen,
   parameter int unsigned DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid_i,
   input  byte_t       s_data_i,
   input  logic        s_last_i,
   output logic        empty_o,
   input  logic        rd_i,
   output byte_t       hdr_o [HDR_LEN],
   output logic [15:0] pkt_len_o,
   output logic [31:0] drop_cnt_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StCapture, StDrop} state_e;

   state_e            state_q, state_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]     count_q, count_d;
   logic [15:0]       bcnt_q, bcnt_d;
   logic [31:0]       drop_cnt_q, drop_cnt_d;
   byte_t             slot_q [DEPTH][HDR_LEN];
   byte_t             slot_d [DEPTH][HDR_LEN];
   logic [15:0]       len_q [DEPTH];
   logic [15:0]       len_d [DEPTH];

   logic        first, full, pop, commit;
   logic [15:0] bcnt_inc;

   assign empty_o  = (count_q == '0);
   assign full     = (count_q == Full);
   assign first    = s_valid_i && (state_q == StIdle);
   assign pop      = rd_i && !empty_o;
   assign commit   = s_valid_i && s_last_i && ((first && !full) || (state_q == StCapture));
   assign bcnt_inc = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      bcnt_d     = bcnt_q;
      drop_cnt_d = drop_cnt_q;
      slot_d     = slot_q;
      len_d      = len_q;

      unique case (state_q)
         StIdle: begin
            if (s_valid_i) begin
               if (!full) begin
                  // First byte lands at index 0; the rest of the slot is cleared for zero-padding.
                  for (int unsigned i = 0; i < HDR_LEN; i++) begin
                     slot_d[wr_ptr_q][i] = (i == 0) ? s_data_i : '0;
                  end
                  bcnt_d = 16'd1;
                  if (s_last_i) len_d[wr_ptr_q] = 16'd1;
                  else          state_d = StCapture;
               end else if (s_last_i) begin
                  drop_cnt_d = drop_cnt_q + 32'd1;
               end else begin
                  state_d = StDrop;
               end
            end
         end
         StCapture: begin
            if (s_valid_i) begin
               for (int unsigned i = 0; i < HDR_LEN; i++) begin
                  if (bcnt_q == 16'(i)) slot_d[wr_ptr_q][i] = s_data_i;
               end
               bcnt_d = bcnt_inc;
               if (s_last_i) begin
                  len_d[wr_ptr_q] = bcnt_inc;
                  state_d         = StIdle;
               end
            end
         end
         StDrop: begin
            if (s_valid_i && s_last_i) begin
               drop_cnt_d = drop_cnt_q + 32'd1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (commit) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (commit && !pop)      count_d = count_q + (PtrW + 1)'(1);
      else if (pop && !commit) count_d = count_q - (PtrW + 1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         bcnt_q     <= '0;
         drop_cnt_q <= '0;
         for (int unsigned s = 0; s < DEPTH; s++) begin
            len_q[s] <= '0;
            for (int unsigned i = 0; i < HDR_LEN; i++) slot_q[s][i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         bcnt_q     <= bcnt_d;
         drop_cnt_q <= drop_cnt_d;
         slot_q     <= slot_d;
         len_q      <= len_d;
      end
   end

   assign hdr_o      = slot_q[rd_ptr_q];
   assign pkt_len_o  = len_q[rd_ptr_q];
   assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_hdr_in_fifo.sv
// Bench for hdr_in_fifo: directed scenarios plus random traffic against a queue-based packet model.
module tb_hdr_in_fifo;
   localparam int HL = 64;
   localparam int DP = 4;

   logic        clk = 0;
   logic        rst;
   logic        s_valid_i, s_last_i, rd_i;
   logic [7:0]  s_data_i;
   logic        empty_o;
   logic [7:0]  hdr_o [HL];
   logic [15:0] pkt_len_o;
   logic [31:0] drop_cnt_o;

   hdr_in_fifo #(.HDR_LEN(HL), .DEPTH(DP)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid_i  (s_valid_i),
      .s_data_i   (s_data_i),
      .s_last_i   (s_last_i),
      .empty_o    (empty_o),
      .rd_i       (rd_i),
      .hdr_o      (hdr_o),
      .pkt_len_o  (pkt_len_o),
      .drop_cnt_o (drop_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]     len;
      logic [HL*8-1:0] hdr;
   } ent_t;

   ent_t       mq[$];
   logic [7:0] cur[$];
   bit         m_active, m_drop;
   int         cur_len;
   int unsigned m_drops;
   int         tests, fails;

   // Drive one cycle of inputs and advance the packet-level model at that clock edge.
   task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic r);
      int   pre;
      bit   do_commit;
      ent_t e;
      s_valid_i = v; s_data_i = d; s_last_i = l; rd_i = r;
      @(posedge clk);
      pre = mq.size();
      do_commit = 0;
      if (v) begin
         if (!m_active) begin
            m_active = 1;
            m_drop   = (pre == DP);
            cur.delete();
            cur_len  = 0;
         end
         if (!m_drop && cur.size() < HL) cur.push_back(d);
         if (cur_len < 65535) cur_len++;
         if (l) begin
            m_active = 0;
            if (m_drop) m_drops++;
            else        do_commit = 1;
         end
      end
      if (r && pre != 0) void'(mq.pop_front());
      if (do_commit) begin
         e.hdr = '0;
         for (int i = 0; i < cur.size(); i++) e.hdr[i*8 +: 8] = cur[i];
         e.len = 16'(cur_len);
         mq.push_back(e);
      end
      #1;
      s_valid_i = 0; s_last_i = 0; rd_i = 0;
   endtask

   task automatic do_reset();
      rst = 1; s_valid_i = 0; s_last_i = 0; rd_i = 0; s_data_i = 0;
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      mq.delete(); cur.delete();
      m_active = 0; m_drop = 0; cur_len = 0; m_drops = 0;
   endtask

   task automatic send(input int n, input logic [7:0] base, input logic pop_last);
      for (int i = 0; i < n; i++)
         cycle(1'b1, base + 8'(i), (i == n - 1), pop_last && (i == n - 1));
   endtask

   task automatic test_reset();
      int bad = 0;
      do_reset();
      tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty_o); end
      tests++; if (drop_cnt_o !== 32'd0) begin fails++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
      tests++; if (pkt_len_o !== 16'd0) begin fails++; $display("FAIL reset_len got %0d want 0", pkt_len_o); end
      for (int i = 0; i < HL; i++) if (hdr_o[i] !== 8'h00) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL reset_hdr %0d nonzero bytes want 0", bad); end
   endtask

   task automatic test_short();
      int bad = 0;
      logic [7:0] exp;
      send(20, 8'h00, 1'b0);
      tests++; if (empty_o !== 1'b0) begin fails++; $display("FAIL short_empty got %b want 0", empty_o); end
      for (int i = 0; i < HL; i++) begin
         exp = (i < 20) ? 8'(i) : 8'h00;
         if (hdr_o[i] !== exp) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL short_hdr %0d bad bytes want 0", bad); end
      tests++; if (pkt_len_o !== 16'd20) begin fails++; $display("FAIL short_len got %0d want 20", pkt_len_o); end
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL short_pop got %b want 1", empty_o); end
   endtask

   task automatic test_long();
      int bad = 0;
      send(100, 8'h30, 1'b0);
      for (int i = 0; i < HL; i++) if (hdr_o[i] !== 8'(8'h30 + i)) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL long_hdr %0d bad bytes want 0", bad); end
      tests++; if (pkt_len_o !== 16'd100) begin fails++; $display("FAIL long_len got %0d want 100", pkt_len_o); end
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_single();
      int bad = 0;
      cycle(1'b1, 8'hAB, 1'b1, 1'b0);
      tests++; if (hdr_o[0] !== 8'hAB) begin fails++; $display("FAIL single_b0 got %h want ab", hdr_o[0]); end
      for (int i = 1; i < HL; i++) if (hdr_o[i] !== 8'h00) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL single_pad %0d nonzero bytes want 0", bad); end
      tests++; if (pkt_len_o !== 16'd1) begin fails++; $display("FAIL single_len got %0d want 1", pkt_len_o); end
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_overflow();
      int unsigned d0 = drop_cnt_o;
      for (int k = 0; k < 5; k++) send(3, 8'(8'h10 * (k + 1)), 1'b0);
      tests++; if (drop_cnt_o !== d0 + 1) begin fails++; $display("FAIL ovf_drop got %0d want %0d", drop_cnt_o, d0 + 1); end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (empty_o !== 1'b0 || hdr_o[0] !== 8'(8'h10 * (k + 1)) || pkt_len_o !== 16'd3) begin
            fails++;
            $display("FAIL ovf_order%0d got e=%b b0=%h len=%0d want e=0 b0=%h len=3",
                     k, empty_o, hdr_o[0], pkt_len_o, 8'(8'h10 * (k + 1)));
         end
         cycle(1'b0, 8'h00, 1'b0, 1'b1);
      end
      tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL ovf_drain got %b want 1", empty_o); end
   endtask

   task automatic test_commit_pop();
      send(4, 8'hA0, 1'b0);
      send(3, 8'hB0, 1'b1);
      tests++; if (empty_o !== 1'b0) begin fails++; $display("FAIL cp_empty got %b want 0", empty_o); end
      tests++; if (hdr_o[0] !== 8'hB0 || pkt_len_o !== 16'd3) begin
         fails++; $display("FAIL cp_head got b0=%h len=%0d want b0=b0 len=3", hdr_o[0], pkt_len_o);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL cp_drain got %b want 1", empty_o); end
   endtask

   task automatic test_reset_mid();
      send(5, 8'h50, 1'b0);
      cycle(1'b1, 8'h60, 1'b0, 1'b0);
      cycle(1'b1, 8'h61, 1'b0, 1'b0);
      do_reset();
      tests++; if (empty_o !== 1'b1 || drop_cnt_o !== 32'd0) begin
         fails++; $display("FAIL rstmid got e=%b drop=%0d want e=1 drop=0", empty_o, drop_cnt_o);
      end
      send(7, 8'h70, 1'b0);
      tests++; if (empty_o !== 1'b0 || hdr_o[0] !== 8'h70 || hdr_o[6] !== 8'h76 || hdr_o[7] !== 8'h00
                   || pkt_len_o !== 16'd7) begin
         fails++; $display("FAIL rstmid_fresh got e=%b b0=%h b6=%h b7=%h len=%0d want 0 70 76 00 7",
                           empty_o, hdr_o[0], hdr_o[6], hdr_o[7], pkt_len_o);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      int bad;
      ent_t e;
      for (int n = 0; n < 1500; n++) begin
         cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 4) == 0));
         tests++;
         if (empty_o !== (mq.size() == 0) || drop_cnt_o !== m_drops) begin
            fails++;
            $display("FAIL rand_state cyc %0d got e=%b drop=%0d want e=%b drop=%0d",
                     n, empty_o, drop_cnt_o, (mq.size() == 0), m_drops);
         end
         if (mq.size() != 0) begin
            e = mq[0];
            bad = 0;
            for (int i = 0; i < HL; i++) if (hdr_o[i] !== e.hdr[i*8 +: 8]) bad++;
            tests++;
            if (bad != 0 || pkt_len_o !== e.len) begin
               fails++;
               $display("FAIL rand_head cyc %0d got len=%0d badbytes=%0d want len=%0d badbytes=0",
                        n, pkt_len_o, bad, e.len);
            end
         end
      end
   endtask

   initial begin
      tests = 0; fails = 0;
      test_reset();
      test_short();
      test_long();
      test_single();
      test_overflow();
      test_commit_pop();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
